key_controller: RTL and testbench

//   Avalon-MM slave that returns debounced push-button state to the Nios II CPU.
//   It is the input-side counterpart of the write-only display controller.
//   It synchronises and debounces KEY_W raw active-low key pins.
//   It latches press events into a write-1-to-clear edge-capture register and

---
 rtl/key_controller.sv | 110 +++++++++++
 tb/tb_key_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_controller.sv
// Avalon-MM slave exposing debounced push-button levels, a W1C press-capture
// register and a masked level interrupt to the CPU.
module key_controller #(
  parameter int unsigned KEY_W   = 4,
  parameter int unsigned DEB_CNT = 1000000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  input  logic [KEY_W-1:0] key,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CNT - 1);

  logic [KEY_W-1:0] sync1_q, sync2_q;
  logic [KEY_W-1:0] pressed;
  logic [KEY_W-1:0] stable_q, stable_d;
  logic [KEY_W-1:0] stable_prev_q;
  logic [KEY_W-1:0] mask_q, mask_d;
  logic [KEY_W-1:0] edge_q, edge_d;
  logic [KEY_W-1:0] w1c;
  logic [CNT_W-1:0] cnt_q [KEY_W];
  logic [CNT_W-1:0] cnt_d [KEY_W];
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  // Only the low KEY_W bits of write data are meaningful.
  assign unused_wdata = ^avs_writedata;

  assign pressed = ~sync2_q;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < KEY_W; i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w1c    = '0;
    mask_d = mask_q;
    if (avs_write && avs_address == 2'd2) begin
      w1c = avs_writedata[KEY_W-1:0];
    end
    if (avs_write && avs_address == 2'd1) begin
      mask_d = avs_writedata[KEY_W-1:0];
    end
    // A press arriving with a clear on the same bit keeps the bit set.
    edge_d = (edge_q & ~w1c) | (stable_q & ~stable_prev_q);
    irq_d  = |(edge_q & mask_q);
  end

  always_comb begin
    rd_mux = '0;
    unique case (avs_address)
      2'd0:    rd_mux[KEY_W-1:0] = stable_q;
      2'd1:    rd_mux[KEY_W-1:0] = mask_q;
      2'd2:    rd_mux[KEY_W-1:0] = edge_q;
      default: rd_mux = '0;
    endcase
    rdata_d = avs_read ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      stable_q      <= '0;
      stable_prev_q <= '0;
      mask_q        <= '0;
      edge_q        <= '0;
      irq_q         <= 1'b0;
      rdata_q       <= '0;
      for (int i = 0; i < KEY_W; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= key;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      mask_q        <= mask_d;
      edge_q        <= edge_d;
      irq_q         <= irq_d;
      rdata_q       <= rdata_d;
      for (int i = 0; i < KEY_W; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_key_controller.sv
// Randomised and directed bench for key_controller; a window-based reference
// model queues expected read data, a monitor checks reads and irq.
module tb_key_controller;

  localparam int D = 8;

  logic        clk;
  logic        rst_n;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  key;
  logic        irq;

  key_controller #(
    .KEY_W  (4),
    .DEB_CNT(D),
    .CNT_W  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_readdata (avs_readdata),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .key          (key),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0]  hist[$];
  logic [31:0] exp_q[$];
  logic [3:0]  m_stable, m_rose, m_edge, m_mask, m_w1c, m_next;
  logic        m_irq;
  logic [31:0] m_mux;
  logic        rd_pend = 1'b0;
  logic        started = 1'b0;
  bit          all_same;
  int          last;

  initial begin
    for (int i = 0; i < D + 2; i++) hist.push_back(4'h0);
    m_stable = '0; m_rose = '0; m_edge = '0; m_mask = '0; m_irq = 1'b0;
  end

  // A key's accepted level flips once its synchronised level has disagreed
  // with it for D consecutive samples (pins reach the debouncer 2 edges late).
  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      hist.push_back(4'h0);
      m_stable = '0; m_rose = '0; m_edge = '0; m_mask = '0; m_irq = 1'b0;
    end else begin
      hist.push_back(~key);
      if (avs_read) begin
        case (avs_address)
          2'd0:    m_mux = {28'h0, m_stable};
          2'd1:    m_mux = {28'h0, m_mask};
          2'd2:    m_mux = {28'h0, m_edge};
          default: m_mux = 32'h0;
        endcase
        exp_q.push_back(m_mux);
        rd_pend = 1'b1;
      end
      m_w1c  = (avs_write && avs_address == 2'd2) ? avs_writedata[3:0] : 4'h0;
      m_irq  = |(m_edge & m_mask);
      m_edge = (m_edge & ~m_w1c) | m_rose;
      if (avs_write && avs_address == 2'd1) m_mask = avs_writedata[3:0];
      last = hist.size() - 1;
      for (int i = 0; i < 4; i++) begin
        all_same = 1'b1;
        for (int j = last - 1 - D; j <= last - 2; j++) begin
          if (hist[j][i] == m_stable[i]) all_same = 1'b0;
        end
        m_next[i] = all_same ? ~m_stable[i] : m_stable[i];
      end
      m_rose   = m_next & ~m_stable;
      m_stable = m_next;
    end
    while (hist.size() > D + 2) void'(hist.pop_front());
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (irq !== m_irq) begin
        errors++;
        $display("FAIL irq at %0t: got %b expected %b", $time, irq, m_irq);
      end
      if (rd_pend) begin
        rd_pend = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL readdata at %0t: no expected value queued", $time);
        end else begin
          m_mux = exp_q.pop_front();
          if (avs_readdata !== m_mux) begin
            errors++;
            $display("FAIL readdata at %0t: got %h expected %h", $time, avs_readdata, m_mux);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  int hold[4];

  initial begin
    rst_n = 1'b0; key = 4'h0; avs_address = 2'd0; avs_read = 1'b0;
    avs_write = 1'b0; avs_writedata = 32'h0;
    cyc(3);
    rst_n = 1'b1;
    // Reset values; DATA still 0 because the held keys are not yet debounced.
    rd(2'd0); rd(2'd1); rd(2'd2);
    key = 4'hF;
    cyc(12);

    // Debounce: steady press, then a short glitch
    key[0] = 1'b0;
    for (int i = 0; i < 20; i++) rd(2'd0);
    key[1] = 1'b0;
    cyc(5);
    key[1] = 1'b1;
    for (int i = 0; i < 12; i++) rd(2'd0);
    rd(2'd2);

    // Edge capture and irq
    wr(2'd2, 32'hFFFF_FFFF);
    key[0] = 1'b1;
    cyc(12);
    wr(2'd1, 32'h1);
    key[0] = 1'b0;
    cyc(12);
    rd(2'd2);
    key[0] = 1'b1;
    cyc(12);
    rd(2'd2);
    wr(2'd2, 32'h1);
    rd(2'd2);
    cyc(2);

    // Masking
    wr(2'd1, 32'h0);
    key[2] = 1'b0;
    cyc(12);
    rd(2'd2);
    wr(2'd1, 32'h4);
    cyc(2);
    rd(2'd1);

    // Clear of bit3 lands on the edge where its press is captured
    key[3] = 1'b0;
    cyc(D + 2);
    wr(2'd2, 32'h8);
    rd(2'd2);
    rd(2'd2);

    // Reset mid-debounce
    key = 4'hF;
    cyc(12);
    key[0] = 1'b0;
    cyc(5);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) rd(2'd0);

    // Random traffic with mixed glitch and stable hold times
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 20);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          key[i]  = ~key[i];
          hold[i] = $urandom_range(1, 20);
        end
      end
      avs_address   = 2'($urandom_range(0, 3));
      avs_read      = ($urandom_range(0, 2) != 0);
      avs_write     = ($urandom_range(0, 5) == 0);
      avs_writedata = $urandom;
      @(negedge clk);
    end
    avs_read = 1'b0;
    avs_write = 1'b0;
    cyc(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
